// File: rtl/nrisc_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nrisc_pkg : shared sizes and demux FSM encodings for the NRISC bank   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package nrisc_pkg;

  localparam int NRISC_NREG  = 16;
  localparam int NRISC_SEL_W = 4;

  typedef enum logic [0:0] {
    DMX_IDLE  = 1'b0,
    DMX_CLEAR = 1'b1
  } dmx_state_e;

endpackage : nrisc_pkg
`default_nettype wire

// File: rtl/nrisc_dec4to16.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nrisc_dec4to16 : 4-bit select plus enable to 16-way one-hot enables   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module nrisc_dec4to16
  import nrisc_pkg::*;
(
  input  logic [NRISC_SEL_W-1:0] i_sel,
  input  logic                   i_en,
  output logic [NRISC_NREG-1:0]  o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_sel] = 1'b1;
    end
  end

endmodule : nrisc_dec4to16
`default_nettype wire

// File: rtl/nrisc_demux_regbank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nrisc_demux_regbank : 1-to-16 write demux into a 16-entry reg bank    |
// | with valid/ready writes and a one-register-per-cycle bulk clear.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module nrisc_demux_regbank
  import nrisc_pkg::*;
#(
  parameter int TAM     = 16,
  parameter int ZERO_R0 = 0
) (
  input  logic                       DEMUX_clk,
  input  logic                       DEMUX_rst_n,
  input  logic [TAM-1:0]             DEMUX_in,
  input  logic [NRISC_SEL_W-1:0]     DEMUX_sel,
  input  logic                       DEMUX_valid,
  output logic                       DEMUX_ready,
  input  logic                       DEMUX_clr,
  output logic                       DEMUX_busy,
  output logic [7:0]                 DEMUX_wcount,
  output logic [NRISC_NREG*TAM-1:0]  DEMUX_Out
);

  dmx_state_e               r_state;
  dmx_state_e               w_state_nxt;
  logic [NRISC_SEL_W-1:0]   r_clr_cnt;
  logic [7:0]               r_wcount;
  logic [TAM-1:0]           r_regs [NRISC_NREG];

  logic                     w_ready;
  logic                     w_clearing;
  logic                     w_wr_fire;
  logic [NRISC_SEL_W-1:0]   w_dec_sel;
  logic                     w_dec_en;
  logic [NRISC_NREG-1:0]    w_we;
  logic [TAM-1:0]           w_wdata;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      DMX_IDLE: begin
        w_ready = ~DEMUX_clr;
        if (DEMUX_clr) begin
          w_state_nxt = DMX_CLEAR;
        end
      end
      DMX_CLEAR: begin
        if (r_clr_cnt == NRISC_SEL_W'(NRISC_NREG - 1)) begin
          w_state_nxt = DMX_IDLE;
        end
      end
      default: w_state_nxt = DMX_IDLE;
    endcase
  end

  assign w_clearing = (r_state == DMX_CLEAR);
  assign w_wr_fire  = DEMUX_valid & w_ready;

  // One decoder serves both paths: the clear counter steers it while clearing.
  assign w_dec_sel = w_clearing ? r_clr_cnt : DEMUX_sel;
  assign w_dec_en  = w_clearing | w_wr_fire;
  assign w_wdata   = w_clearing ? '0 : DEMUX_in;

  nrisc_dec4to16 u_dec (
    .i_sel    (w_dec_sel),
    .i_en     (w_dec_en),
    .o_onehot (w_we)
  );

  always_ff @(posedge DEMUX_clk) begin
    if (!DEMUX_rst_n) begin
      r_state   <= DMX_IDLE;
      r_clr_cnt <= '0;
      r_wcount  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clearing ? r_clr_cnt + 1'b1 : '0;
      if (w_wr_fire) begin
        r_wcount <= r_wcount + 8'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NRISC_NREG; gi++) begin : g_reg
    localparam bit c_hard_zero = (ZERO_R0 != 0) && (gi == 0);

    always_ff @(posedge DEMUX_clk) begin
      if (!DEMUX_rst_n) begin
        r_regs[gi] <= '0;
      end else if (w_we[gi]) begin
        r_regs[gi] <= c_hard_zero ? '0 : w_wdata;
      end
    end

    assign DEMUX_Out[gi*TAM +: TAM] = r_regs[gi];
  end

  assign DEMUX_ready  = w_ready;
  assign DEMUX_busy   = w_clearing;
  assign DEMUX_wcount = r_wcount;

endmodule : nrisc_demux_regbank
`default_nettype wire

// File: tb/tb_nrisc_demux_regbank.sv
`default_nettype none
// Bench for nrisc_demux_regbank: two instances (ZERO_R0=0 and ZERO_R0=1) share
// one stimulus stream and are checked every cycle against a behavioural model.
module tb_nrisc_demux_regbank;

  logic              clk;
  logic              rst_n;
  logic [15:0]       din;
  logic [3:0]        sel;
  logic              valid;
  logic              clr;
  logic [1:0]        rdy;
  logic [1:0]        busy;
  logic [1:0][7:0]   wc;
  logic [1:0][255:0] outb;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  nrisc_demux_regbank #(.TAM(16), .ZERO_R0(0)) dut0 (
    .DEMUX_clk(clk), .DEMUX_rst_n(rst_n), .DEMUX_in(din), .DEMUX_sel(sel),
    .DEMUX_valid(valid), .DEMUX_ready(rdy[0]), .DEMUX_clr(clr),
    .DEMUX_busy(busy[0]), .DEMUX_wcount(wc[0]), .DEMUX_Out(outb[0])
  );

  nrisc_demux_regbank #(.TAM(16), .ZERO_R0(1)) dut1 (
    .DEMUX_clk(clk), .DEMUX_rst_n(rst_n), .DEMUX_in(din), .DEMUX_sel(sel),
    .DEMUX_valid(valid), .DEMUX_ready(rdy[1]), .DEMUX_clr(clr),
    .DEMUX_busy(busy[1]), .DEMUX_wcount(wc[1]), .DEMUX_Out(outb[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain register array, write counter, and clear progress.
  logic [15:0] m_regs [2][16];
  logic [7:0]  m_wc   [2];
  bit          m_clearing [2];
  int          m_cleared  [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int r = 0; r < 16; r++) m_regs[d][r] <= 16'h0;
        m_wc[d]       <= 8'd0;
        m_clearing[d] <= 1'b0;
        m_cleared[d]  <= 0;
      end else if (m_clearing[d]) begin
        m_regs[d][m_cleared[d]] <= 16'h0;
        m_cleared[d]            <= m_cleared[d] + 1;
        if (m_cleared[d] + 1 == 16) m_clearing[d] <= 1'b0;
      end else if (clr) begin
        m_clearing[d] <= 1'b1;
        m_cleared[d]  <= 0;
      end else if (valid) begin
        if (!(d == 1 && sel == 4'd0)) m_regs[d][sel] <= din;
        m_wc[d] <= m_wc[d] + 8'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] reg_of(input int d, input int r);
    return outb[d][r*16 +: 16];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("cyc ready d%0d", d), 32'(rdy[d]), 32'(!m_clearing[d] && !clr));
        check($sformatf("cyc busy d%0d", d), 32'(busy[d]), 32'(m_clearing[d]));
        check($sformatf("cyc wcount d%0d", d), 32'(wc[d]), 32'(m_wc[d]));
        for (int r = 0; r < 16; r++)
          check($sformatf("cyc reg%0d d%0d", r, d), 32'(reg_of(d, r)), 32'(m_regs[d][r]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] s, input logic [15:0] v);
    sel = s; din = v; valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  initial begin
    int nbusy;
    rst_n = 1'b0; din = '0; sel = '0; valid = 1'b0; clr = 1'b0;
    repeat (2) step();
    chk_en = 1'b1;
    rst_n  = 1'b1;

    @(negedge clk);
    check("rst busy", 32'(busy[0]), 32'd0);
    check("rst ready", 32'(rdy[0]), 32'd1);
    check("rst wcount", 32'(wc[0]), 32'd0);
    check("rst out zero", 32'(outb[0] == 256'd0), 32'd1);
    step();

    write(4'd5, 16'hA5A5);
    @(negedge clk);
    check("t1 reg5", 32'(reg_of(0, 5)), 32'h0000A5A5);
    check("t1 wcount", 32'(wc[0]), 32'd1);
    check("t1 others zero", 32'((outb[0] & ~(256'hFFFF << 80)) == 256'd0), 32'd1);
    step();

    for (int i = 0; i < 16; i++) begin
      sel = 4'(i); din = 16'h1000 + 16'(i); valid = 1'b1;
      step();
    end
    valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++)
      check($sformatf("t2 reg%0d", i), 32'(reg_of(0, i)), 32'h1000 + 32'(i));
    check("t2 wcount", 32'(wc[0]), 32'd17);
    check("t2 zr reg0", 32'(reg_of(1, 0)), 32'd0);
    step();

    // Clear with a write held pending on the input; it lands once ready returns.
    clr = 1'b1; sel = 4'd9; din = 16'h7777; valid = 1'b1;
    step();
    clr = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k > 0 && k <= 16) check($sformatf("t3 cleared reg%0d", k - 1), 32'(reg_of(0, k - 1)), 32'd0);
      if (k < 16) check($sformatf("t3 pending reg%0d", k), 32'(reg_of(0, k)), 32'h1000 + 32'(k));
      if (!busy[0]) break;
      nbusy++;
    end
    check("t3 busy cycles", 32'(nbusy), 32'd16);
    check("t3 ready after", 32'(rdy[0]), 32'd1);
    step();
    valid = 1'b0;
    @(negedge clk);
    check("t3 held write reg9", 32'(reg_of(0, 9)), 32'h00007777);
    check("t3 wcount", 32'(wc[0]), 32'd18);
    step();

    write(4'd3, 16'h1234);
    clr = 1'b1; sel = 4'd3; din = 16'hBEEF; valid = 1'b1;
    @(negedge clk);
    check("t4 ready low", 32'(rdy[0]), 32'd0);
    step();
    clr = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("t4 reg3 kept", 32'(reg_of(0, 3)), 32'h00001234);
    check("t4 wcount", 32'(wc[0]), 32'd19);
    check("t4 busy", 32'(busy[0]), 32'd1);
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy[0]) break;
      nbusy++;
    end
    check("t4 clear done", 32'(busy[0]), 32'd0);
    step();

    for (int i = 8; i < 16; i++) write(4'(i), 16'h0800 + 16'(i));
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (7) step();
    @(negedge clk);
    check("t5 reg8 before rst", 32'(reg_of(0, 8)), 32'h00000808);
    check("t5 busy before rst", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5 busy", 32'(busy[0]), 32'd0);
    check("t5 ready", 32'(rdy[0]), 32'd1);
    check("t5 wcount", 32'(wc[0]), 32'd0);
    check("t5 out zero", 32'(outb[0] == 256'd0), 32'd1);
    step();

    write(4'd0, 16'hFFFF);
    @(negedge clk);
    check("t6 zr reg0", 32'(reg_of(1, 0)), 32'd0);
    check("t6 zr wcount", 32'(wc[1]), 32'd1);
    check("t6 reg0 normal", 32'(reg_of(0, 0)), 32'h0000FFFF);
    step();
    for (int i = 1; i < 256; i++) begin
      sel = 4'(i % 16); din = 16'(i); valid = 1'b1;
      step();
    end
    valid = 1'b0;
    @(negedge clk);
    check("t6 zr wrap", 32'(wc[1]), 32'd0);
    check("t6 wrap", 32'(wc[0]), 32'd0);
    check("t6 zr reg0 end", 32'(reg_of(1, 0)), 32'd0);
    check("t6 reg15 end", 32'(reg_of(0, 15)), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_nrisc_demux_regbank
`default_nettype wire
